// File: rtl/araddr_arbiter_pkg.sv
// Shared definitions for the read-address arbiter: FSM encoding, 4 KB page
// constants and the {id, len, addr} FIFO word layout.
package araddr_arb_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } state_e;

  localparam int unsigned PAGE_BYTES = 4096;
  localparam int unsigned PAGE_OFS_W = 12;
  // One bit wider than the page offset so 4096 - 0 is representable.
  localparam int unsigned REM_W      = 13;

  // FIFO word: addr in the LSBs, then len, then id in the MSBs.
  localparam int unsigned ADDR_LSB = 0;

  function automatic int unsigned len_lsb(input int unsigned addr_w);
    return addr_w;
  endfunction

  function automatic int unsigned id_lsb(input int unsigned addr_w, input int unsigned len_w);
    return addr_w + len_w;
  endfunction

  function automatic int unsigned fifo_w(input int unsigned id_w, input int unsigned len_w,
                                         input int unsigned addr_w);
    return id_w + len_w + addr_w;
  endfunction

endpackage

// File: rtl/araddr_arbiter_if.sv
// Request-side and FIFO-side bus of the read-address arbiter.
interface araddr_arbiter_if #(
  parameter int N_REQ  = 4,
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 8
);
  localparam int ID_W   = $clog2(N_REQ);
  localparam int FIFO_W = ID_W + LEN_W + ADDR_W;

  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ-1:0]        req_ready;
  logic [N_REQ*ADDR_W-1:0] req_addr;
  logic [N_REQ*LEN_W-1:0]  req_len;
  logic [FIFO_W-1:0]       fifo_wr_data;
  logic                    fifo_wr_en;
  logic                    fifo_wr_vld;

  // slave: the arbiter; master: requesters plus the araddr FIFO.
  modport slave (
    input  req_valid, req_addr, req_len, fifo_wr_vld,
    output req_ready, fifo_wr_data, fifo_wr_en
  );

  modport master (
    output req_valid, req_addr, req_len, fifo_wr_vld,
    input  req_ready, fifo_wr_data, fifo_wr_en
  );
endinterface

// File: rtl/araddr_arbiter_rr_arb.sv
// Round-robin requester select: combinational grant searching upward from a
// registered pointer, which moves past the winner whenever a grant is taken.
module araddr_rr_arb #(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic             take,
  output logic [N_REQ-1:0] grant_oh,
  output logic [ID_W-1:0]  grant_idx,
  output logic             grant_any
);

  logic [ID_W-1:0] ptr_q, ptr_d;
  int unsigned     idx;

  always_comb begin
    // NOTE: every comb output gets a default first so no path can infer a latch.
    grant_oh  = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    idx       = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(ptr_q) + k) % N_REQ;
      if (!grant_any && req[idx]) begin
        grant_any = 1'b1;
        grant_idx = ID_W'(idx);
      end
    end
    grant_oh[grant_idx] = grant_any;

    ptr_d = ptr_q;
    if (take) ptr_d = (int'(grant_idx) == N_REQ - 1) ? '0 : grant_idx + ID_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: flops use <= so all of them sample pre-edge values in the same step.
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/araddr_arbiter.sv
// Arbitrates N read-address requesters into one araddr FIFO, splitting bursts
// at 4 KB boundaries and throttling on the count of outstanding bursts.
module araddr_arbiter
  import araddr_arb_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int ADDR_W     = 32,
  parameter int LEN_W      = 8,
  parameter int BYTES_LOG2 = 4,
  parameter int MAX_OUT    = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  araddr_arbiter_if.slave     bus,
  input  logic                rd_done,
  output logic [3:0]          outstanding,
  output logic                busy,
  output logic                err
);

  localparam int ID_W   = $clog2(N_REQ);
  localparam int FIFO_W = fifo_w(ID_W, LEN_W, ADDR_W);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              err_q, err_d;

  logic [N_REQ-1:0]  grant_oh;
  logic [ID_W-1:0]   grant_idx;
  logic              grant_any;
  logic              take;
  logic [REM_W-1:0]  rem;
  logic              fits;
  logic [LEN_W-1:0]  piece_len;
  logic              push;
  logic              dec;

  assign take = (state_q == ST_IDLE) && grant_any;

  araddr_rr_arb #(.N_REQ(N_REQ), .ID_W(ID_W)) u_rr (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (bus.req_valid),
    .take      (take),
    .grant_oh  (grant_oh),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  always_comb begin
    // Beats left before the current address reaches the next 4 KB page.
    rem       = (REM_W'(PAGE_BYTES) - {1'b0, addr_q[PAGE_OFS_W-1:0]}) >> BYTES_LOG2;
    fits      = (32'(len_q) + 32'd1) <= 32'(rem);
    piece_len = fits ? len_q : LEN_W'(rem - REM_W'(1));
    push      = (state_q == ST_ISSUE) && bus.fifo_wr_vld && (cnt_q < 4'(MAX_OUT));
    dec       = rd_done && (cnt_q != 4'd0);

    state_d = state_q;
    addr_d  = addr_q;
    len_d   = len_q;
    id_d    = id_q;
    case (state_q)
      ST_IDLE: if (take) begin
        state_d = ST_ISSUE;
        addr_d  = bus.req_addr[int'(grant_idx)*ADDR_W +: ADDR_W];
        len_d   = bus.req_len[int'(grant_idx)*LEN_W +: LEN_W];
        id_d    = grant_idx;
      end
      ST_ISSUE: if (push) begin
        if (fits) begin
          state_d = ST_IDLE;
        end else begin
          addr_d = addr_q + ADDR_W'(32'(rem) << BYTES_LOG2);
          len_d  = len_q - LEN_W'(rem);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A push with a coinciding legal rd_done leaves the count unchanged.
    cnt_d = cnt_q;
    if (push && !dec)      cnt_d = cnt_q + 4'd1;
    else if (!push && dec) cnt_d = cnt_q - 4'd1;
    err_d = err_q || (rd_done && (cnt_q == 4'd0));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      id_q    <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      id_q    <= id_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign bus.req_ready    = take ? grant_oh : '0;
  assign bus.fifo_wr_en   = push;
  assign bus.fifo_wr_data = FIFO_W'({id_q, piece_len, addr_q});
  assign outstanding      = cnt_q;
  assign busy             = (state_q != ST_IDLE);
  assign err              = err_q;

endmodule

// File: tb/tb_araddr_arbiter.sv
// Directed bench for araddr_arbiter: grant order, 4 KB split, throttling,
// FIFO back-pressure, outstanding accounting and reset behaviour.
module tb_araddr_arbiter;

  localparam int N_REQ  = 4;
  localparam int ADDR_W = 32;
  localparam int LEN_W  = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rd_done;
  logic [3:0] outstanding;
  logic       busy;
  logic       err;

  int n_tests = 0;
  int n_fail  = 0;

  araddr_arbiter_if #(.N_REQ(N_REQ), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) bus ();

  araddr_arbiter #(.N_REQ(N_REQ), .ADDR_W(ADDR_W), .LEN_W(LEN_W),
                   .BYTES_LOG2(4), .MAX_OUT(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .rd_done     (rd_done),
    .outstanding (outstanding),
    .busy        (busy),
    .err         (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [63:0] pk(input int id, input int len, input logic [31:0] addr);
    return 64'({2'(id), 8'(len), addr});
  endfunction

  // Inputs change 1 ns after a rising edge; outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [31:0] addr, input int len);
    bus.req_addr[i*ADDR_W +: ADDR_W] = addr;
    bus.req_len[i*LEN_W +: LEN_W]    = LEN_W'(len);
  endtask

  task automatic do_reset();
    rst_n           = 1'b0;
    bus.req_valid   = '0;
    bus.req_addr    = '0;
    bus.req_len     = '0;
    bus.fifo_wr_vld = 1'b1;
    rd_done         = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Returns at the falling edge of the cycle that shows a grant (or after the budget).
  task automatic wait_grant(output logic [3:0] g);
    logic found;
    found = 1'b0;
    g     = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.req_ready != '0) begin
        found = 1'b1;
        g     = bus.req_ready;
        break;
      end
      tick();
    end
    check("grant_seen", 64'(found), 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [3:0] g;

    // Reset values while rst_n is held low
    rst_n           = 1'b0;
    bus.req_valid   = '0;
    bus.req_addr    = '0;
    bus.req_len     = '0;
    bus.fifo_wr_vld = 1'b1;
    rd_done         = 1'b0;
    @(negedge clk);
    check("rst_ready", 64'(bus.req_ready), 64'h0);
    check("rst_wr_en", 64'(bus.fifo_wr_en), 64'h0);
    check("rst_data",  64'(bus.fifo_wr_data), 64'h0);
    check("rst_busy",  64'(busy), 64'h0);
    check("rst_outst", 64'(outstanding), 64'h0);
    check("rst_err",   64'(err), 64'h0);

    // Single request: grant at T, push at T+1
    do_reset();
    set_req(0, 32'h1000, 15);
    bus.req_valid = 4'b0001;
    @(negedge clk);
    check("t1_ready",    64'(bus.req_ready), 64'h1);
    check("t1_no_push0", 64'(bus.fifo_wr_en), 64'h0);
    tick();
    bus.req_valid = '0;
    @(negedge clk);
    check("t1_push", 64'(bus.fifo_wr_en), 64'h1);
    check("t1_data", 64'(bus.fifo_wr_data), pk(0, 15, 32'h1000));
    check("t1_busy", 64'(busy), 64'h1);
    tick();
    @(negedge clk);
    check("t1_outst", 64'(outstanding), 64'h1);
    check("t1_idle",  64'(busy), 64'h0);
    tick();

    // All requesters valid: grant order 0,1,2,3,0
    do_reset();
    for (int i = 0; i < N_REQ; i++) set_req(i, 32'(i * 32'h100), 0);
    bus.req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_grant(g);
      check($sformatf("rr_grant%0d", k), 64'(g), 64'(4'b0001 << (k % 4)));
      tick();
    end
    bus.req_valid = '0;
    @(negedge clk);
    tick();
    @(negedge clk);
    check("rr_outst", 64'(outstanding), 64'd5);
    tick();

    // 4 KB crossing: 0x0FC0 len 15 splits into 4 + 12 beats
    do_reset();
    set_req(2, 32'h0FC0, 15);
    bus.req_valid = 4'b0100;
    @(negedge clk);
    check("sp_ready", 64'(bus.req_ready), 64'h4);
    tick();
    bus.req_valid = '0;
    @(negedge clk);
    check("sp_push0", 64'(bus.fifo_wr_en), 64'h1);
    check("sp_data0", 64'(bus.fifo_wr_data), pk(2, 3, 32'h0FC0));
    tick();
    @(negedge clk);
    check("sp_push1", 64'(bus.fifo_wr_en), 64'h1);
    check("sp_data1", 64'(bus.fifo_wr_data), pk(2, 11, 32'h1000));
    tick();
    @(negedge clk);
    check("sp_outst", 64'(outstanding), 64'd2);
    check("sp_idle",  64'(busy), 64'h0);
    tick();

    // Nine requests with no completions: 9th stalls at MAX_OUT
    do_reset();
    set_req(0, 32'h2000, 0);
    for (int k = 0; k < 9; k++) begin
      bus.req_valid = 4'b0001;
      wait_grant(g);
      tick();
      bus.req_valid = '0;
      @(negedge clk);
      check($sformatf("mo_push%0d", k), 64'(bus.fifo_wr_en), (k < 8) ? 64'd1 : 64'd0);
      tick();
    end
    @(negedge clk);
    check("mo_stall_busy", 64'(busy), 64'h1);
    check("mo_stall_en",   64'(bus.fifo_wr_en), 64'h0);
    check("mo_outst8",     64'(outstanding), 64'd8);
    tick();
    rd_done = 1'b1;
    @(negedge clk);
    check("mo_same_cyc", 64'(bus.fifo_wr_en), 64'h0);
    tick();
    rd_done = 1'b0;
    @(negedge clk);
    check("mo_outst7", 64'(outstanding), 64'd7);
    check("mo_release", 64'(bus.fifo_wr_en), 64'h1);
    check("mo_data",    64'(bus.fifo_wr_data), pk(0, 0, 32'h2000));
    tick();
    @(negedge clk);
    check("mo_outst8b", 64'(outstanding), 64'd8);
    check("mo_idle",    64'(busy), 64'h0);
    tick();

    // FIFO full for 5 cycles in ISSUE: no push, data held
    do_reset();
    set_req(1, 32'h3000, 7);
    bus.req_valid   = 4'b0010;
    bus.fifo_wr_vld = 1'b0;
    @(negedge clk);
    check("bp_ready", 64'(bus.req_ready), 64'h2);
    tick();
    bus.req_valid = '0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("bp_hold_en%0d", k), 64'(bus.fifo_wr_en), 64'h0);
      check($sformatf("bp_hold_d%0d", k), 64'(bus.fifo_wr_data), pk(1, 7, 32'h3000));
      tick();
    end
    bus.fifo_wr_vld = 1'b1;
    @(negedge clk);
    check("bp_push", 64'(bus.fifo_wr_en), 64'h1);
    tick();
    @(negedge clk);
    check("bp_outst", 64'(outstanding), 64'd1);
    tick();

    // Push with rd_done in the same cycle, then rd_done at zero
    set_req(3, 32'h4000, 3);
    bus.req_valid = 4'b1000;
    @(negedge clk);
    check("rd_ready", 64'(bus.req_ready), 64'h8);
    tick();
    bus.req_valid = '0;
    rd_done       = 1'b1;
    @(negedge clk);
    check("rd_push", 64'(bus.fifo_wr_en), 64'h1);
    tick();
    rd_done = 1'b0;
    @(negedge clk);
    check("rd_both_outst", 64'(outstanding), 64'd1);
    check("rd_both_err",   64'(err), 64'h0);
    tick();
    rd_done = 1'b1;
    tick();
    rd_done = 1'b0;
    @(negedge clk);
    check("rd_dec_outst", 64'(outstanding), 64'd0);
    check("rd_dec_err",   64'(err), 64'h0);
    tick();
    rd_done = 1'b1;
    tick();
    rd_done = 1'b0;
    @(negedge clk);
    check("rd_under_outst", 64'(outstanding), 64'd0);
    check("rd_under_err",   64'(err), 64'h1);
    tick();
    @(negedge clk);
    check("rd_err_sticky", 64'(err), 64'h1);
    tick();

    // Reset in the middle of ISSUE drops the latched request
    do_reset();
    @(negedge clk);
    check("rst_err_clr", 64'(err), 64'h0);
    tick();
    set_req(0, 32'h5000, 1);
    bus.req_valid   = 4'b0001;
    bus.fifo_wr_vld = 1'b0;
    @(negedge clk);
    check("mr_ready", 64'(bus.req_ready), 64'h1);
    tick();
    bus.req_valid = '0;
    @(negedge clk);
    check("mr_busy", 64'(busy), 64'h1);
    tick();
    rst_n = 1'b0;
    @(negedge clk);
    check("mr_rst_busy", 64'(busy), 64'h0);
    check("mr_rst_data", 64'(bus.fifo_wr_data), 64'h0);
    tick();
    rst_n           = 1'b1;
    bus.fifo_wr_vld = 1'b1;
    @(negedge clk);
    check("mr_no_push0", 64'(bus.fifo_wr_en), 64'h0);
    tick();
    @(negedge clk);
    check("mr_no_push1", 64'(bus.fifo_wr_en), 64'h0);
    check("mr_outst",    64'(outstanding), 64'd0);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
